linear_layer_start_fifo_ctrl: RTL and testbench

//   Control wrapper of the start-token FIFOs between Linear_Layer_i4xi4_q dataflow processes (producer -> PE_i4xi4_pack_2x2).

---
 rtl/linear_layer_start_fifo_ctrl.sv | 96 +++++++++
 tb/tb_linear_layer_start_fifo_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/linear_layer_start_fifo_ctrl.sv
// Start-token FIFO control between Linear_Layer_i4xi4_q dataflow processes.
// Shift-register storage with occupancy count, registered full/empty flags and handshake.
module linear_layer_start_fifo_ctrl #(
   parameter int DATA_WIDTH = 1,
   parameter int ADDR_WIDTH = 1,
   parameter int DEPTH      = 2
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic                  if_write_ce,
   input  logic                  if_write,
   input  logic [DATA_WIDTH-1:0] if_din,
   output logic                  if_full_n,
   input  logic                  if_read_ce,
   input  logic                  if_read,
   output logic [DATA_WIDTH-1:0] if_dout,
   output logic                  if_empty_n,
   output logic [ADDR_WIDTH:0]   if_num_data_valid,
   output logic [ADDR_WIDTH:0]   if_fifo_cap
);

   generate
      if (DEPTH < 2) begin : g_depth_chk
         $error("linear_layer_start_fifo_ctrl: DEPTH must be >= 2");
      end
      if (ADDR_WIDTH != $clog2(DEPTH)) begin : g_addr_chk
         $error("linear_layer_start_fifo_ctrl: ADDR_WIDTH must equal clog2(DEPTH)");
      end
   endgenerate

   localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH+1)'(1);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
   logic                  empty_n_q, empty_n_d;
   logic                  full_n_q, full_n_d;
   logic                  push, pop;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [DATA_WIDTH-1:0] dout_c;

   assign push = if_write & if_write_ce & full_n_q;
   assign pop  = if_read & if_read_ce & empty_n_q;

   // Storage is deliberately not reset: reset only discards entries through cnt.
   always_ff @(posedge ap_clk) begin
      if (push) begin
         mem_q[0] <= if_din;
         for (int unsigned i = 1; i < DEPTH; i++) begin
            mem_q[i] <= mem_q[i-1];
         end
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (push && !pop) begin
         cnt_d = cnt_q + CNT_ONE;
      end else if (pop && !push) begin
         cnt_d = cnt_q - CNT_ONE;
      end
      empty_n_d = (cnt_d != '0);
      full_n_d  = (cnt_d != DEPTH_C);
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         cnt_q     <= '0;
         empty_n_q <= 1'b0;
         full_n_q  <= 1'b1;
      end else begin
         cnt_q     <= cnt_d;
         empty_n_q <= empty_n_d;
         full_n_q  <= full_n_d;
      end
   end

   // The oldest entry sits at slot cnt-1; a mux keeps non-power-of-two depths in range.
   assign rd_addr = ADDR_WIDTH'(cnt_q - CNT_ONE);

   always_comb begin
      dout_c = mem_q[0];
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (rd_addr == ADDR_WIDTH'(i)) begin
            dout_c = mem_q[i];
         end
      end
   end

   assign if_dout           = dout_c;
   assign if_empty_n        = empty_n_q;
   assign if_full_n         = full_n_q;
   assign if_num_data_valid = cnt_q;
   assign if_fifo_cap       = DEPTH_C;

endmodule

// File: tb/tb_linear_layer_start_fifo_ctrl.sv
// Directed bench for linear_layer_start_fifo_ctrl: expected tokens queued at push, popped by a read monitor.
module tb_linear_layer_start_fifo_ctrl;

   localparam int DW = 8;
   localparam int AW = 1;
   localparam int DP = 2;

   logic          ap_clk = 1'b0;
   logic          ap_rst_n;
   logic          if_write_ce, if_write, if_full_n;
   logic          if_read_ce, if_read, if_empty_n;
   logic [DW-1:0] if_din, if_dout;
   logic [AW:0]   if_num_data_valid, if_fifo_cap;

   int unsigned   n_vec  = 0;
   int unsigned   n_fail = 0;
   logic [DW-1:0] exp_q[$];

   linear_layer_start_fifo_ctrl #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .DEPTH     (DP)
   ) dut (
      .ap_clk           (ap_clk),
      .ap_rst_n         (ap_rst_n),
      .if_write_ce      (if_write_ce),
      .if_write         (if_write),
      .if_din           (if_din),
      .if_full_n        (if_full_n),
      .if_read_ce       (if_read_ce),
      .if_read          (if_read),
      .if_dout          (if_dout),
      .if_empty_n       (if_empty_n),
      .if_num_data_valid(if_num_data_valid),
      .if_fifo_cap      (if_fifo_cap)
   );

   always #5 ap_clk = ~ap_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic w, input logic r, input logic [DW-1:0] d);
      if_write = w;
      if_read  = r;
      if_din   = d;
   endtask

   task automatic tick;
      @(posedge ap_clk);
      #1;
   endtask

   // Read monitor: every accepted pop must present the oldest expected token.
   always @(negedge ap_clk) begin
      if (ap_rst_n && if_read && if_read_ce && if_empty_n) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL pop_unexpected: got 0x%0h, expected no token", if_dout);
         end else begin
            logic [DW-1:0] e;
            e = exp_q.pop_front();
            if (if_dout !== e) begin
               n_fail++;
               $display("FAIL pop_data: got 0x%0h, expected 0x%0h", if_dout, e);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      ap_rst_n    = 1'b0;
      if_write_ce = 1'b1;
      if_read_ce  = 1'b1;
      drive(1'b0, 1'b0, 8'h00);
      tick; tick;
      ap_rst_n = 1'b1;

      // 1: reset state, idle for 10 cycles
      check("rst_empty_n", if_empty_n, 0);
      check("rst_full_n", if_full_n, 1);
      check("rst_count", if_num_data_valid, 0);
      check("fifo_cap", if_fifo_cap, DP);
      for (int i = 0; i < 10; i++) begin
         tick;
         check("idle_count", if_num_data_valid, 0);
      end
      check("idle_empty_n", if_empty_n, 0);
      check("idle_full_n", if_full_n, 1);

      // 2: fill, overflow ignored, drain
      drive(1'b1, 1'b0, 8'hA1); exp_q.push_back(8'hA1); tick;
      check("t2_empty_n", if_empty_n, 1);
      check("t2_count1", if_num_data_valid, 1);
      check("t2_dout1", if_dout, 8'hA1);
      drive(1'b1, 1'b0, 8'hB2); exp_q.push_back(8'hB2); tick;
      check("t2_full_n", if_full_n, 0);
      check("t2_count2", if_num_data_valid, 2);
      check("t2_dout2", if_dout, 8'hA1);
      drive(1'b1, 1'b0, 8'hC3); tick;
      check("t2_ovf_count", if_num_data_valid, 2);
      check("t2_ovf_dout", if_dout, 8'hA1);
      drive(1'b0, 1'b1, 8'h00); tick;
      check("t2_pop_count", if_num_data_valid, 1);
      check("t2_pop_full_n", if_full_n, 1);
      check("t2_pop_dout", if_dout, 8'hB2);
      tick;
      drive(1'b0, 1'b0, 8'h00);
      check("t2_drained", if_empty_n, 0);
      check("t2_drained_cnt", if_num_data_valid, 0);

      // 3: simultaneous push and pop at count 1
      drive(1'b1, 1'b0, 8'h11); exp_q.push_back(8'h11); tick;
      drive(1'b1, 1'b1, 8'h22); exp_q.push_back(8'h22); tick;
      check("t3_count", if_num_data_valid, 1);
      check("t3_dout", if_dout, 8'h22);
      drive(1'b0, 1'b1, 8'h00); tick;
      drive(1'b0, 1'b0, 8'h00);
      check("t3_drained", if_empty_n, 0);

      // 4: full with write+read: pop only
      drive(1'b1, 1'b0, 8'h33); exp_q.push_back(8'h33); tick;
      drive(1'b1, 1'b0, 8'h44); exp_q.push_back(8'h44); tick;
      check("t4_full_n0", if_full_n, 0);
      drive(1'b1, 1'b1, 8'h55); tick;
      check("t4_count", if_num_data_valid, 1);
      check("t4_full_n1", if_full_n, 1);
      check("t4_dout", if_dout, 8'h44);
      drive(1'b0, 1'b1, 8'h00); tick;
      drive(1'b0, 1'b0, 8'h00);
      check("t4_drained", if_num_data_valid, 0);

      // 5: empty with write+read: push only, no fall-through
      drive(1'b1, 1'b1, 8'h77);
      #1;
      check("t5_no_fallthru", (if_dout == 8'h77), 0);
      exp_q.push_back(8'h77); tick;
      check("t5_count", if_num_data_valid, 1);
      check("t5_empty_n", if_empty_n, 1);
      check("t5_dout", if_dout, 8'h77);
      drive(1'b1, 1'b0, 8'h88); exp_q.push_back(8'h88); tick;
      drive(1'b0, 1'b0, 8'h00);
      check("t5_count2", if_num_data_valid, 2);

      // 6: asynchronous reset mid-cycle at count 2
      @(posedge ap_clk); #3;
      ap_rst_n = 1'b0;
      #1;
      check("t6_empty_n", if_empty_n, 0);
      check("t6_full_n", if_full_n, 1);
      check("t6_count", if_num_data_valid, 0);
      exp_q.delete();
      #2;
      ap_rst_n = 1'b1;
      drive(1'b1, 1'b0, 8'h9E); exp_q.push_back(8'h9E); tick;
      check("t6_dout", if_dout, 8'h9E);
      check("t6_count1", if_num_data_valid, 1);
      drive(1'b0, 1'b1, 8'h00); tick;
      drive(1'b0, 1'b0, 8'h00);
      check("t6_drained", if_empty_n, 0);

      // clock enables freeze only their own side
      if_write_ce = 1'b0;
      drive(1'b1, 1'b0, 8'h5A); tick;
      check("wce_frozen", if_num_data_valid, 0);
      if_write_ce = 1'b1;
      exp_q.push_back(8'h5A); tick;
      check("wce_push", if_num_data_valid, 1);
      if_read_ce = 1'b0;
      drive(1'b0, 1'b1, 8'h00); tick;
      check("rce_frozen", if_num_data_valid, 1);
      if_read_ce = 1'b1;
      tick;
      drive(1'b0, 1'b0, 8'h00);
      check("rce_pop", if_num_data_valid, 0);

      tick;
      check("queue_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
